// File: rtl/lbuf_pkg.sv
// Shared definitions for the sprite line-buffer scanout engine and its bench.
// Holds geometry, bank encoding and the scan FSM state type.
package lbuf_pkg;

    localparam int LBUF_AW = 10;
    localparam int LBUF_DW = 8;

    // Bank encoding; the renderer always owns the opposite bank.
    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CLR  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/lbuf_scanout_if.sv
// Port-1 bus shared by the two line-buffer banks: one address/write-data path,
// per-bank read/write strobes and per-bank registered read data.
interface lbuf_scanout_if
    import lbuf_pkg::*;
#(
    parameter int AW = LBUF_AW
);

    logic [AW-1:0]      ad;
    logic [LBUF_DW-1:0] wd;
    logic               re_a;
    logic               re_b;
    logic               we_a;
    logic               we_b;
    logic [LBUF_DW-1:0] dt_a;
    logic [LBUF_DW-1:0] dt_b;

    modport master (
        output ad, wd, re_a, re_b, we_a, we_b,
        input  dt_a, dt_b
    );

    modport slave (
        input  ad, wd, re_a, re_b, we_a, we_b,
        output dt_a, dt_b
    );

endinterface

// File: rtl/lbuf_scanout.sv
// Read-and-clear scanout of the display line-buffer bank: each pixel is read,
// handed to the mixer and written back as zero for the next render pass.
module lbuf_scanout
    import lbuf_pkg::*;
#(
    parameter int AW     = LBUF_AW,
    parameter int XSTART = 0,
    parameter int XCOUNT = 256
) (
    input  logic               cl,
    input  logic               rst,
    input  logic               lstart,
    input  logic               pce,
    output logic               bank,
    output logic               active,
    output logic [LBUF_DW-1:0] pix,
    output logic               pix_opq,
    output logic               pix_stb,
    output logic               pce_err,
    lbuf_scanout_if.master     lb
);

    localparam logic [AW-1:0] START_AD = AW'(XSTART);
    localparam logic [AW:0]   END_CNT  = (AW + 1)'(XCOUNT);

    scan_state_e        state;
    logic               pending;
    logic [AW-1:0]      ad;
    logic [AW:0]        cnt;
    logic [AW:0]        cnt_nxt;
    logic [LBUF_DW-1:0] dt;
    logic               start_now;

    // NOTE: every always_comb output is assigned on every pass, so no latch is inferred.
    always_comb begin
        dt        = (bank == BANK_B) ? lb.dt_b : lb.dt_a;
        cnt_nxt   = cnt + 1'b1;
        // A start is deferred out of RD/CLR so the in-flight read/clear pair finishes.
        start_now = ((state == IDLE) && lstart) ||
                    ((state == CLR) && (lstart || pending));
    end

    assign lb.ad   = ad;
    assign lb.wd   = '0;
    assign lb.re_a = (state == RD)  && (bank == BANK_A);
    assign lb.re_b = (state == RD)  && (bank == BANK_B);
    assign lb.we_a = (state == CLR) && (bank == BANK_A);
    assign lb.we_b = (state == CLR) && (bank == BANK_B);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cl) begin
        // NOTE: synchronous reset; an in-flight clear is simply abandoned.
        if (rst) begin
            state   <= IDLE;
            bank    <= BANK_A;
            active  <= 1'b0;
            ad      <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            pix     <= '0;
            pix_opq <= 1'b0;
            pix_stb <= 1'b0;
            pce_err <= 1'b0;
        end else begin
            pix_stb <= 1'b0;
            pce_err <= pce && (state != IDLE);
            pending <= (state == RD) && lstart;

            if (start_now) begin
                bank   <= ~bank;
                ad     <= START_AD;
                cnt    <= '0;
                active <= 1'b1;
            end else if (state == CLR) begin
                ad  <= ad + 1'b1;
                cnt <= cnt_nxt;
                if (cnt_nxt == END_CNT) begin
                    active <= 1'b0;
                end
            end

            unique case (state)
                IDLE: begin
                    if (!lstart && active && pce) begin
                        state <= RD;
                    end
                end
                RD: begin
                    state <= CLR;
                end
                CLR: begin
                    state   <= IDLE;
                    pix     <= dt;
                    pix_opq <= (dt != '0);
                    pix_stb <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbuf_scanout.sv
// Bench for lbuf_scanout: two instances (plain and wrapping short line) against
// a pixel-level model with its own line-buffer memories.
module tb_lbuf_scanout;
    import lbuf_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic cl = 1'b0;
    logic rst;
    logic lstart;
    logic pce;

    logic       bank0, active0, opq0, stb0, err0;
    logic [7:0] pix0;
    logic       bank1, active1, opq1, stb1, err1;
    logic [7:0] pix1;

    lbuf_scanout_if #(.AW(AW)) lb0 ();
    lbuf_scanout_if #(.AW(AW)) lb1 ();

    lbuf_scanout #(.AW(AW), .XSTART(0), .XCOUNT(256)) dut0 (
        .cl(cl), .rst(rst), .lstart(lstart), .pce(pce),
        .bank(bank0), .active(active0), .pix(pix0), .pix_opq(opq0),
        .pix_stb(stb0), .pce_err(err0), .lb(lb0.master)
    );

    lbuf_scanout #(.AW(AW), .XSTART(1020), .XCOUNT(8)) dut1 (
        .cl(cl), .rst(rst), .lstart(lstart), .pce(pce),
        .bank(bank1), .active(active1), .pix(pix1), .pix_opq(opq1),
        .pix_stb(stb1), .pce_err(err1), .lb(lb1.master)
    );

    always #5 cl = ~cl;

    typedef struct packed {
        logic          bank;
        logic          active;
        logic          stb;
        logic          opq;
        logic          err;
        logic [7:0]    pix;
        logic [7:0]    wd;
        logic [AW-1:0] ad;
        logic [3:0]    str;   // {re_a, re_b, we_a, we_b}
    } obs_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem  [2][2][DEPTH];
    logic [7:0] smem [2][2][DEPTH];
    int         m_bank   [2];
    bit         m_active [2];
    int         m_addr   [2];
    int         m_cnt    [2];
    logic [7:0] m_pix    [2];

    function automatic int xs(input int i);
        return (i == 0) ? 0 : 1020;
    endfunction

    function automatic int xc(input int i);
        return (i == 0) ? 256 : 8;
    endfunction

    function automatic logic [31:0] re_mask(input int b);
        return (b != 0) ? 32'h4 : 32'h8;
    endfunction

    function automatic logic [31:0] we_mask(input int b);
        return (b != 0) ? 32'h1 : 32'h2;
    endfunction

    function automatic obs_t snap(input int i);
        obs_t o;
        if (i == 0) begin
            o = '{bank0, active0, stb0, opq0, err0, pix0, lb0.wd, lb0.ad,
                  {lb0.re_a, lb0.re_b, lb0.we_a, lb0.we_b}};
        end else begin
            o = '{bank1, active1, stb1, opq1, err1, pix1, lb1.wd, lb1.ad,
                  {lb1.re_a, lb1.re_b, lb1.we_a, lb1.we_b}};
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_dt(input int i, input int b, input logic [7:0] v);
        if (i == 0 && b == 0) lb0.dt_a = v;
        if (i == 0 && b == 1) lb0.dt_b = v;
        if (i == 1 && b == 0) lb1.dt_a = v;
        if (i == 1 && b == 1) lb1.dt_b = v;
    endtask

    // One clock; the line-buffer banks answer the strobes seen before the edge.
    task automatic step();
        obs_t o [2];
        for (int i = 0; i < 2; i++) o[i] = snap(i);
        @(posedge cl);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (o[i].str[3]) set_dt(i, 0, mem[i][0][o[i].ad]);
            if (o[i].str[2]) set_dt(i, 1, mem[i][1][o[i].ad]);
            if (o[i].str[1]) mem[i][0][o[i].ad] = o[i].wd;
            if (o[i].str[0]) mem[i][1][o[i].ad] = o[i].wd;
        end
    endtask

    task automatic render(input int i, input int b, input int a, input logic [7:0] v);
        mem[i][b][a]  = v;
        smem[i][b][a] = v;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < DEPTH; a++)
                    render(i, b, a, 8'($urandom));
    endtask

    task automatic render_some();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 8; k++)
                render(i, m_bank[i] ^ 1, $urandom_range(0, DEPTH - 1),
                       ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
    endtask

    task automatic m_reset(input int i);
        m_bank[i] = 0; m_active[i] = 1'b0; m_addr[i] = 0; m_cnt[i] = 0; m_pix[i] = 8'h00;
    endtask

    task automatic m_start(input int i);
        m_bank[i] ^= 1; m_addr[i] = xs(i); m_cnt[i] = 0; m_active[i] = 1'b1;
    endtask

    task automatic m_pixel(input int i);
        m_pix[i] = smem[i][m_bank[i]][m_addr[i]];
        smem[i][m_bank[i]][m_addr[i]] = 8'h00;
        m_addr[i] = (m_addr[i] + 1) % DEPTH;
        m_cnt[i]++;
        if (m_cnt[i] == xc(i)) m_active[i] = 1'b0;
    endtask

    task automatic do_lstart();
        obs_t o;
        lstart = 1'b1; step(); lstart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_start(i);
            o = snap(i);
            chk($sformatf("ls_bank%0d", i), 32'(o.bank), 32'(m_bank[i]));
            chk($sformatf("ls_ad%0d", i), 32'(o.ad), 32'(m_addr[i]));
            chk($sformatf("ls_active%0d", i), 32'(o.active), 32'h1);
            chk($sformatf("ls_str%0d", i), 32'(o.str), 32'h0);
        end
    endtask

    // PCE at t; with viol the pulse is held into the RD cycle.
    task automatic do_pixel(input int extra, input bit viol);
        obs_t o;
        bit   act [2];
        int   oa  [2];
        int   ob  [2];
        for (int i = 0; i < 2; i++) begin
            act[i] = m_active[i]; oa[i] = m_addr[i]; ob[i] = m_bank[i];
        end
        pce = 1'b1; step(); pce = viol;
        for (int i = 0; i < 2; i++) begin
            o = snap(i);
            chk($sformatf("rd_str%0d", i), 32'(o.str), act[i] ? re_mask(ob[i]) : 32'h0);
            if (act[i]) chk($sformatf("rd_ad%0d", i), 32'(o.ad), 32'(oa[i]));
        end
        step(); pce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            o = snap(i);
            chk($sformatf("clr_str%0d", i), 32'(o.str), act[i] ? we_mask(ob[i]) : 32'h0);
            chk($sformatf("pce_err%0d", i), 32'(o.err), 32'(viol && act[i]));
            if (act[i]) begin
                chk($sformatf("clr_ad%0d", i), 32'(o.ad), 32'(oa[i]));
                chk($sformatf("clr_wd%0d", i), 32'(o.wd), 32'h0);
            end
        end
        step();
        for (int i = 0; i < 2; i++) begin
            if (act[i]) m_pixel(i);
            o = snap(i);
            chk($sformatf("stb%0d", i), 32'(o.stb), 32'(act[i]));
            chk($sformatf("pix%0d", i), 32'(o.pix), 32'(m_pix[i]));
            chk($sformatf("opq%0d", i), 32'(o.opq), 32'(m_pix[i] != 8'h00));
            chk($sformatf("active%0d", i), 32'(o.active), 32'(m_active[i]));
            if (act[i]) begin
                chk($sformatf("next_ad%0d", i), 32'(o.ad), 32'(m_addr[i]));
                chk($sformatf("cleared%0d", i), 32'(mem[i][ob[i]][oa[i]]), 32'h0);
            end
        end
        repeat (extra) step();
    endtask

    // LSTART lands in RD (and in CLR as well when hold2); both lines must be active.
    task automatic lstart_in_rd(input bit hold2);
        obs_t o;
        int   oa [2];
        int   ob [2];
        for (int i = 0; i < 2; i++) begin
            oa[i] = m_addr[i]; ob[i] = m_bank[i];
        end
        pce = 1'b1; step(); pce = 1'b0; lstart = 1'b1;
        for (int i = 0; i < 2; i++) begin
            o = snap(i);
            chk($sformatf("lrd_str%0d", i), 32'(o.str), re_mask(ob[i]));
        end
        step(); lstart = hold2;
        for (int i = 0; i < 2; i++) begin
            o = snap(i);
            chk($sformatf("lclr_str%0d", i), 32'(o.str), we_mask(ob[i]));
            chk($sformatf("lclr_ad%0d", i), 32'(o.ad), 32'(oa[i]));
            chk($sformatf("lclr_bank%0d", i), 32'(o.bank), 32'(ob[i]));
        end
        step(); lstart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_pixel(i);
            m_start(i);
            o = snap(i);
            chk($sformatf("lsw_pix%0d", i), 32'(o.pix), 32'(m_pix[i]));
            chk($sformatf("lsw_stb%0d", i), 32'(o.stb), 32'h1);
            chk($sformatf("lsw_bank%0d", i), 32'(o.bank), 32'(m_bank[i]));
            chk($sformatf("lsw_ad%0d", i), 32'(o.ad), 32'(m_addr[i]));
            chk($sformatf("lsw_active%0d", i), 32'(o.active), 32'h1);
            chk($sformatf("lsw_cleared%0d", i), 32'(mem[i][ob[i]][oa[i]]), 32'h0);
        end
        step();
        for (int i = 0; i < 2; i++) begin
            o = snap(i);
            chk($sformatf("lsw_once%0d", i), 32'(o.bank), 32'(m_bank[i]));
            chk($sformatf("lsw_quiet%0d", i), 32'(o.str), 32'h0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        obs_t o;
        for (int i = 0; i < 2; i++) begin
            o = snap(i);
            chk($sformatf("%s_bank%0d", tag, i), 32'(o.bank), 32'h0);
            chk($sformatf("%s_active%0d", tag, i), 32'(o.active), 32'h0);
            chk($sformatf("%s_ad%0d", tag, i), 32'(o.ad), 32'h0);
            chk($sformatf("%s_str%0d", tag, i), 32'(o.str), 32'h0);
            chk($sformatf("%s_pix%0d", tag, i), 32'(o.pix), 32'h0);
            chk($sformatf("%s_opq%0d", tag, i), 32'(o.opq), 32'h0);
            chk($sformatf("%s_stb%0d", tag, i), 32'(o.stb), 32'h0);
        end
    endtask

    initial begin
        int r;
        rst = 1'b1; lstart = 1'b0; pce = 1'b0;
        lb0.dt_a = '0; lb0.dt_b = '0; lb1.dt_a = '0; lb1.dt_b = '0;
        fill_all();
        for (int i = 0; i < 2; i++) m_reset(i);
        repeat (2) step();
        rst = 1'b0;
        check_reset_state("rst");

        do_pixel(1, 1'b0);

        render(0, 1, 0, 8'h00);
        render(0, 1, 1, 8'h15);
        render(0, 1, 2, 8'h80);
        render(0, 1, 3, 8'hFF);
        do_lstart();
        repeat (2) begin
            step();
            chk("pre_pce_str0", 32'({lb0.re_a, lb0.re_b, lb0.we_a, lb0.we_b}), 32'h0);
        end

        for (int k = 0; k < 4; k++) do_pixel(1, 1'b0);
        // Second instance finishes its 8-pixel line across the wrap, then ignores PCE.
        for (int k = 0; k < 6; k++) do_pixel(1, 1'b0);

        do_lstart();
        for (int k = 0; k < 7; k++) do_pixel(0, 1'b0);
        lstart_in_rd(1'b0);
        lstart_in_rd(1'b1);
        do_pixel(0, 1'b1);

        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            if (r < 30) render_some();
            if (r < 10) begin
                do_lstart();
            end else if (r < 16 && m_active[0] && m_active[1]) begin
                lstart_in_rd(1'($urandom_range(0, 1)));
            end else if (r < 20) begin
                do_pixel($urandom_range(0, 2), 1'b1);
            end else begin
                do_pixel($urandom_range(0, 2), 1'b0);
            end
        end

        if (!(m_active[0] && m_active[1])) do_lstart();
        pce = 1'b1; step(); pce = 1'b0; step();
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 2; i++) m_reset(i);
        check_reset_state("midrst");
        repeat (2) begin
            step();
            chk("midrst_quiet0", 32'({lb0.re_a, lb0.re_b, lb0.we_a, lb0.we_b}), 32'h0);
            chk("midrst_quiet1", 32'({lb1.re_a, lb1.re_b, lb1.we_a, lb1.we_b}), 32'h0);
        end

        fill_all();
        do_lstart();
        for (int k = 0; k < 3; k++) do_pixel(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbuf_scanout.md
# lbuf_scanout

Read-and-clear scanout engine for the double-buffered 1024x8 sprite line buffers. It drives port 1 (RE/WE/WD) of two line-buffer instances (bank A/B). Each pixel is read from the display bank, presented to the video mixer, and written back as zero so the bank is clean when it next becomes the sprite-render bank. The sprite renderer writes the other bank through port 0.

## Interface
- AW, 10, line-buffer address width
- XSTART, 0, first buffer address scanned each line
- XCOUNT, 256, pixels scanned per line (1..2**AW)

- CL  in  1  system clock; all logic on posedge
- RST  in  1  synchronous, active-high reset
- LSTART  in  1  one-cycle line-start pulse; swaps banks and restarts scan
- PCE  in  1  pixel enable; one pixel per pulse; min spacing 3 CL cycles
- BANK  out  1  display bank (0=A, 1=B); renderer writes bank ~BANK
- AD  out  AW  port-1 address, shared by both banks
- WD  out  8  port-1 write data, constant 0
- RE_A / RE_B  out  1  read strobe, display bank only
- WE_A / WE_B  out  1  clear-write strobe, display bank only
- DT_A / DT_B  in  8  port-1 read data (1-cycle registered latency)
- PIX  out  8  scanned pixel
- PIX_OPQ  out  1  PIX != 0 (sprite pixel present)
- PIX_STB  out  1  one-cycle pulse, PIX/PIX_OPQ updated
- ACTIVE  out  1  scan in progress for current line

## Operation
- States: IDLE, RD, CLR. Strobes decode from registered state; the non-display bank's RE/WE are always 0.
- IDLE: if ACTIVE and PCE -> RD. PCE while !ACTIVE is ignored and PIX is unchanged.
- RD: RE(display)=1, AD=current address -> CLR unconditionally.
- CLR: WE(display)=1, WD=0, same AD. Capture the display bank's DT into PIX, set PIX_OPQ=(DT!=0), pulse PIX_STB next cycle. Address +1 mod 2**AW and count +1. If count reaches XCOUNT then ACTIVE=0. -> IDLE.
- LSTART in IDLE: BANK toggles, AD=XSTART, count=0, ACTIVE=1 next cycle.
- LSTART in RD or CLR: latched as pending. The read/clear pair always completes. The pending start is applied on the cycle the FSM returns to IDLE, so no location is left uncleared.
- LSTART while one is already pending: merged into a single swap.
- PCE arriving in RD/CLR: ignored, counted as a protocol violation; the engine is not required to recover the pixel.
- Address wrap: XSTART+XCOUNT > 2**AW wraps to 0.
- Reset: state IDLE, BANK=0, ACTIVE=0, AD=0, count=0, pending=0, PIX=0, PIX_OPQ=0, PIX_STB=0, all RE/WE=0. Reset mid-pixel abandons the clear.

## Timing
- PCE at cycle t -> RE at t+1 -> WE at t+2 (DT valid at t+2) -> PIX/PIX_STB at t+3.
- Latency PCE->PIX_STB is 3 cycles. The next PCE is accepted no earlier than t+3.
- LSTART at t (IDLE) -> BANK/ACTIVE/AD updated at t+1. A PCE at t+1 is accepted.
- The clear-write of a location always lands in the same bank and address as its read.

## Structure
- Shared package lbuf_pkg holds:
  - the state enum (IDLE/RD/CLR);
  - LBUF_AW=10 and LBUF_DW=8;
  - the bank encoding constants.
- No sub-module. Both LBUF1024_8 instances and the renderer sit in the parent video block. This block only steers strobes and muxes DT_A/DT_B by BANK.

## Test plan
- Reset then LSTART: BANK=1, AD=0, ACTIVE=1, all strobes 0 before any PCE.
- Preload bank B addr 0..3 = 0x00,0x15,0x80,0xFF. LSTART, then 4 PCE 4 cycles apart. Required:
  - PIX = 00,15,80,FF with PIX_OPQ = 0,1,1,1, each 3 cycles after its PCE;
  - WE_B at addr 0..3 with WD=0;
  - a read-back of bank B gives 0x00 at addr 0..3.
- XCOUNT=4, 6 PCE pulses: ACTIVE drops after the 4th CLR. PCE 5/6 produce no RE/WE/PIX_STB.
- LSTART asserted in the RD cycle of pixel addr 7: WE at addr 7 in the old bank still occurs. BANK toggles the following cycle, AD=XSTART.
- XSTART=1020, XCOUNT=8: AD sequence 1020..1023,0..3, ACTIVE clears after addr 3.
- RST asserted in the CLR cycle: next cycle all outputs are at reset values, BANK=0, and no further WE is issued.
